// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with a 2-entry skid buffer and a registered in_ready.
// Optional stall counter output enabled by defining IFID_STALL_CNT_EN.
module if_id_stage #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(32'hE000_0000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_q,
    output logic [DATA_W-1:0] pc_q,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rn,
    output logic [3:0]        rd,
    output logic [11:0]       Immediate
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_instr;
    logic [DATA_W-1:0] r_main_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_instr;
    logic [DATA_W-1:0] r_skid_pc;
    logic              r_in_ready;

    logic              w_accept;
    logic              w_consume;
    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_instr_nxt;
    logic [DATA_W-1:0] w_main_pc_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_instr_nxt;
    logic [DATA_W-1:0] w_skid_pc_nxt;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_main_valid && out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_instr_nxt = r_main_instr;
        w_main_pc_nxt    = r_main_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (flush) begin
            // pc_q deliberately keeps its value; only the instruction turns into a NOP
            w_main_valid_nxt = 1'b0;
            w_main_instr_nxt = NOP_INSTR;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_instr_nxt = r_skid_instr;
                w_main_pc_nxt    = r_skid_pc;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_instr_nxt = in_instr;
                w_main_pc_nxt    = in_pc;
            end else begin
                w_main_valid_nxt = 1'b0;
                w_main_instr_nxt = NOP_INSTR;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = in_instr;
            w_skid_pc_nxt    = in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_instr <= w_main_instr_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            // registered copy of !skid_valid keeps in_ready independent of out_ready
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign instr_q   = r_main_instr;
    assign pc_q      = r_main_pc;
    assign cond      = r_main_instr[31:28];
    assign op        = r_main_instr[27:26];
    assign funct     = r_main_instr[25:20];
    assign rn        = r_main_instr[19:16];
    assign rd        = r_main_instr[15:12];
    assign Immediate = r_main_instr[11:0];

`ifdef IFID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // stall counter not built in this configuration
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: FIFO scoreboard of accepted words, popped on each consume.
// Define IFID_STALL_CNT_EN to also exercise the stall counter.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'hE000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] immediate;
`ifdef IFID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    txn_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    if_id_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_q   (instr_q),
        .pc_q      (pc_q),
        .cond      (cond),
        .op        (op),
        .funct     (funct),
        .rn        (rn),
        .rd        (rd),
        .Immediate (immediate)
`ifdef IFID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe the handshake before the edge, update the scoreboard, then advance one clock.
    task automatic step();
        txn_t exp;
        if (out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got instr=%h pc=%h, want no output", instr_q, pc_q);
            end else begin
                exp = sb.pop_front();
                if (instr_q !== exp.instr || pc_q !== exp.pc)
                    $display("FAIL sb_data: got instr=%h pc=%h, want instr=%h pc=%h",
                             instr_q, pc_q, exp.instr, exp.pc);
                else
                    n_pass++;
            end
        end
        if (in_valid && in_ready && !flush) begin
            exp.instr = in_instr;
            exp.pc    = in_pc;
            sb.push_back(exp);
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (instr_q !== NOP) $display("FAIL reset_instr_q: got %h want %h", instr_q, NOP); else n_pass++;
        n_total++; if (cond !== 4'hE) $display("FAIL reset_cond: got %h want e", cond); else n_pass++;
        n_total++; if (immediate !== 12'h000) $display("FAIL reset_imm: got %h want 000", immediate); else n_pass++;
        n_total++; if ({op, funct, rn, rd} !== 16'h0) $display("FAIL reset_fields: got %h want 0", {op, funct, rn, rd}); else n_pass++;
        n_total++; if (pc_q !== 32'h0) $display("FAIL reset_pc_q: got %h want 0", pc_q); else n_pass++;
        #1 reset = 1'b0;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_instr = 32'hE3A0_1078; in_pc = 32'h0000_0008; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (cond !== 4'hE) $display("FAIL single_cond: got %h want e", cond); else n_pass++;
        n_total++; if (op !== 2'd0) $display("FAIL single_op: got %h want 0", op); else n_pass++;
        n_total++; if (funct !== 6'h3A) $display("FAIL single_funct: got %h want 3a", funct); else n_pass++;
        n_total++; if (rn !== 4'h0) $display("FAIL single_rn: got %h want 0", rn); else n_pass++;
        n_total++; if (rd !== 4'h1) $display("FAIL single_rd: got %h want 1", rd); else n_pass++;
        n_total++; if (immediate !== 12'h078) $display("FAIL single_imm: got %h want 078", immediate); else n_pass++;
        n_total++; if (pc_q !== 32'h8) $display("FAIL single_pc_q: got %h want 8", pc_q); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h1111_1111; in_pc = 32'h100;
        step();
        in_instr = 32'h2222_2222; in_pc = 32'h104;
        step();
        in_valid = 1'b0;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
        n_total++; if (instr_q !== 32'h1111_1111) $display("FAIL bp_instr_q: got %h want 11111111", instr_q); else n_pass++;
        step();
        n_total++; if (instr_q !== 32'h1111_1111 || pc_q !== 32'h100)
            $display("FAIL bp_hold: got instr=%h pc=%h want 11111111/100", instr_q, pc_q); else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b1 || instr_q !== 32'h2222_2222)
            $display("FAIL bp_second: got valid=%b instr=%h want 1/22222222", out_valid, instr_q); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_empty: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h200 + 32'(4 * i);
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
            step();
            if (i > 0) begin
                n_total++; if (sb.size() != 1) $display("FAIL stream_occupancy[%0d]: got %0d want 1", i, sb.size()); else n_pass++;
            end
        end
        in_valid = 1'b0;
        step();
        n_total++; if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL stream_drain: got pending=%0d valid=%b want 0/0", sb.size(), out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h4444_4444; in_pc = 32'h300;
        step();
        in_instr = 32'h5555_5555; in_pc = 32'h304;
        step();
        flush = 1'b1; in_instr = 32'h3333_3333; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (instr_q !== NOP) $display("FAIL flush_instr_q: got %h want %h", instr_q, NOP); else n_pass++;
        n_total++; if (pc_q !== 32'h300) $display("FAIL flush_pc_q: got %h want 300", pc_q); else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (out_valid !== 1'b0) $display("FAIL flush_c_leak[%0d]: got %b want 0", i, out_valid); else n_pass++;
        end
        // main full, skid empty: in_ready=1 yet the flush-cycle word must still be dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h6666_6666; in_pc = 32'h310;
        step();
        out_ready = 1'b1; flush = 1'b1; in_instr = 32'h3333_3333; in_pc = 32'h314;
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL flush2[%0d]: got valid=%b ready=%b want 0/1", i, out_valid, in_ready); else n_pass++;
            step();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h7777_7777; in_pc = 32'h400;
        step();
        in_instr = 32'h8888_8888; in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready); else n_pass++;
        n_total++; if (instr_q !== NOP || pc_q !== 32'h0)
            $display("FAIL rstmid_regs: got instr=%h pc=%h want %h/0", instr_q, pc_q, NOP); else n_pass++;
        sb.delete();
        #1 reset = 1'b0;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_skid: got %b want 0", out_valid); else n_pass++;
    endtask

`ifdef IFID_STALL_CNT_EN
    task automatic test_stall_cnt();
        out_ready = 1'b0; in_valid = 1'b0;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL stall_reset: got %0d want 0", stall_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) step();
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL stall_empty: got %0d want 0", stall_cnt); else n_pass++;
        in_valid = 1'b1; in_instr = 32'h9999_9999; in_pc = 32'h500;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_total++; if (stall_cnt !== 16'd5) $display("FAIL stall_five: got %0d want 5", stall_cnt); else n_pass++;
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        n_total++; if (stall_cnt !== 16'd5) $display("FAIL stall_after_flush: got %0d want 5", stall_cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_mid();
`ifdef IFID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
